hex_display_scan: RTL

//   Parametrised multiplexed hex 7-segment driver; successor to the fixed 4-digit driver.

---
 rtl/hex_display_scan.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/hex_display_scan.sv
// hex_display_scan
//   Multiplexed hex 7-segment driver. It scans DIGITS hex digits onto one
//   shared segment bus, with a slot period of DIV clocks per digit. Inputs
//   are captured once per frame into shadow registers so a frame is never
//   torn. It also provides per-digit decimal points, leading-zero blanking,
//   16-level PWM brightness and a frame-start strobe.
//
// Ports
//   clk       clock
//   rst       asynchronous reset, active-high
//   data      4*DIGITS  nibble i shows on digit i (digit 0 rightmost, anode[0])
//   dp        DIGITS    decimal point request per digit
//   blank_lz  1         blank leading zero digits (digit 0 never blanked)
//   bright    4         brightness, 0 = 1/16 duty .. 15 = full slot
//   anode     DIGITS    digit enables, polarity set by AN_ACTIVE_LOW
//   seg       8         {dp,g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   frame     1         one-cycle pulse with the first output of a new snapshot

module hex_display_scan #(
    parameter int DIGITS         = 4,
    parameter int DIV            = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    input  logic [3:0]            bright,
    output logic [DIGITS-1:0]     anode,
    output logic [7:0]            seg,
    output logic                  frame
);

    localparam int CW = $clog2(DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = CW + 5;

    localparam logic [CW-1:0]     CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_dp;
    logic                sh_blz;
    logic [3:0]          sh_bright;

    logic                load_en;
    logic [4*DIGITS-1:0] v_data;
    logic [DIGITS-1:0]   v_dp;
    logic                v_blz;
    logic [3:0]          v_bright;
    logic [3:0]          nibble;
    logic                dp_bit;
    logic                nz_above;
    logic                blanked;
    logic                lit;
    logic                active;
    logic [DIGITS-1:0]   onehot;
    logic [PW-1:0]       pwm_lhs;
    logic [PW-1:0]       pwm_rhs;
    logic [DIGITS-1:0]   anode_nxt;
    logic [7:0]          seg_nxt;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    // Prescaler and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (idx == IDX_LAST)
                idx <= '0;
            else
                idx <= idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Frame snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_data   <= '0;
            sh_dp     <= '0;
            sh_blz    <= 1'b0;
            sh_bright <= '0;
        end else if (load_en) begin
            sh_data   <= data;
            sh_dp     <= dp;
            sh_blz    <= blank_lz;
            sh_bright <= bright;
        end
    end

    always_comb begin
        load_en = (cnt == '0) && (idx == '0);

        // On the load cycle the registered output is computed from the values
        // being captured, so the frame pulse coincides with new data on the pins.
        v_data   = load_en ? data     : sh_data;
        v_dp     = load_en ? dp       : sh_dp;
        v_blz    = load_en ? blank_lz : sh_blz;
        v_bright = load_en ? bright   : sh_bright;

        nibble   = '0;
        dp_bit   = 1'b0;
        nz_above = 1'b0;
        onehot   = '0;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            if (IW'(j) == idx) begin
                nibble    = v_data[4*j +: 4];
                dp_bit    = v_dp[j];
                onehot[j] = 1'b1;
            end
            if ((IW'(j) >= idx) && (v_data[4*j +: 4] != 4'h0))
                nz_above = 1'b1;
        end

        blanked = v_blz && (idx != '0) && !nz_above;

        // Duty: lit while cnt*16 < (bright+1)*DIV, evaluated without truncation.
        pwm_lhs = PW'({cnt, 4'h0});
        pwm_rhs = PW'({1'b0, v_bright} + 5'd1) * PW'(DIV);
        lit     = pwm_lhs < pwm_rhs;

        active    = lit && !blanked;
        anode_nxt = (active ? onehot : '0) ^ AN_OFF;
        seg_nxt   = (active ? {dp_bit, glyph(nibble)} : 8'h00) ^ SEG_OFF;
    end

    // Registered pin drivers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode <= AN_OFF;
            seg   <= SEG_OFF;
            frame <= 1'b0;
        end else begin
            anode <= anode_nxt;
            seg   <= seg_nxt;
            frame <= load_en;
        end
    end

endmodule
